// File: rtl/mux_pkg.sv
// Shared definitions for the streaming N:1 multiplexer: arbitration mode
// encodings and the wrapped channel-index increment.
package mux_pkg;

  localparam int MUX_FIXED = 0;
  localparam int MUX_RR    = 1;
  localparam int MUX_STEER = 2;

  // Next channel index after idx, wrapping n-1 back to 0 (any n, not only powers of two).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping around. With ptr tied to 0 it degenerates to lowest-index-wins.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_masked;

  assign w_dbl   = {req, req};
  assign gnt_any = |req;

  // Lower copy keeps only bits at/above ptr; upper copy supplies the wrap-around.
  generate
    for (genvar gi = 0; gi < 2 * N; gi++) begin : g_mask
      assign w_masked[gi] = w_dbl[gi] && (gi >= int'(ptr));
    end
  endgenerate

  always_comb begin
    gnt_idx = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (w_masked[i]) gnt_idx = SW'(i % N);
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N:1 valid/ready stream multiplexer with elaboration-time arbitration mode
// and a single registered output stage.
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = MUX_RR,
  parameter int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          w_load;
  logic          w_accept;
  logic          w_gnt_any;
  logic [SW-1:0] w_gnt_idx;
  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic          r_out_valid;
  logic [W-1:0]  w_chan [N];

  assign w_load   = !r_out_valid || out_ready;
  assign w_accept = w_load && w_gnt_any;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign w_chan[gi]   = in_data[gi*W +: W];
      assign in_ready[gi] = rst_n && w_accept && (w_gnt_idx == SW'(gi));
    end

    if (MODE == MUX_STEER) begin : g_steer
      logic w_sel_ok;
      // Out-of-range steering (non-power-of-two N) must never grant.
      assign w_sel_ok  = (int'(sel) < N);
      assign w_gnt_any = w_sel_ok && in_valid[sel];
      assign w_gnt_idx = sel;
      assign r_ptr     = '0;
    end else begin : g_pick
      logic [SW-1:0] w_pick_ptr;
      logic          w_unused_sel;
      assign w_unused_sel = ^sel;

      rr_pick #(.N(N), .SW(SW)) u_pick (
        .req     (in_valid),
        .ptr     (w_pick_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
      );

      if (MODE == MUX_RR) begin : g_rr
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ptr <= '0;
          end else if (w_accept) begin
            r_ptr <= SW'(wrap_inc(32'(w_gnt_idx), N));
          end
        end
        assign w_pick_ptr = r_ptr;
      end else begin : g_fixed
        assign r_ptr      = '0;
        assign w_pick_ptr = '0;
      end
    end
  endgenerate

  // Data/sel hold their last values when a load slot finds no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      r_out_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_out_data <= w_chan[w_gnt_idx];
        r_out_sel  <= w_gnt_idx;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Drives five differently configured multiplexers with shared stimulus and
// checks every cycle against a queue-free behavioural arbitration model.
module tb_mux_rr_stream;
  localparam int NI = 5;

  // Instances: 0 N4/RR, 1 N4/steer, 2 N3/fixed, 3 N3/RR, 4 N3/steer
  int pn [NI] = '{4, 4, 3, 3, 3};
  int pm [NI] = '{1, 2, 0, 1, 2};

  logic        clk;
  logic        rst_n = 1'b1;
  logic [31:0] din   = '0;
  logic [3:0]  vin   = '0;
  logic [1:0]  sel   = '0;
  logic        ordy  = 1'b0;

  logic       ov   [NI];
  logic [7:0] od   [NI];
  logic [1:0] osel [NI];
  logic [3:0] rdy  [NI];
  logic [3:0] rdy_a, rdy_b;
  logic [2:0] rdy_c, rdy_d, rdy_e;

  int mv [NI], md [NI], ms [NI], mp [NI];
  int n_vec = 0;
  int n_err = 0;

  mux_rr_stream #(.N(4), .W(8), .MODE(1)) u_a (.clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(vin),
    .in_ready(rdy_a), .sel(sel), .out_data(od[0]), .out_sel(osel[0]), .out_valid(ov[0]), .out_ready(ordy));
  mux_rr_stream #(.N(4), .W(8), .MODE(2)) u_b (.clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(vin),
    .in_ready(rdy_b), .sel(sel), .out_data(od[1]), .out_sel(osel[1]), .out_valid(ov[1]), .out_ready(ordy));
  mux_rr_stream #(.N(3), .W(8), .MODE(0)) u_c (.clk(clk), .rst_n(rst_n), .in_data(din[23:0]), .in_valid(vin[2:0]),
    .in_ready(rdy_c), .sel(sel), .out_data(od[2]), .out_sel(osel[2]), .out_valid(ov[2]), .out_ready(ordy));
  mux_rr_stream #(.N(3), .W(8), .MODE(1)) u_d (.clk(clk), .rst_n(rst_n), .in_data(din[23:0]), .in_valid(vin[2:0]),
    .in_ready(rdy_d), .sel(sel), .out_data(od[3]), .out_sel(osel[3]), .out_valid(ov[3]), .out_ready(ordy));
  mux_rr_stream #(.N(3), .W(8), .MODE(2)) u_e (.clk(clk), .rst_n(rst_n), .in_data(din[23:0]), .in_valid(vin[2:0]),
    .in_ready(rdy_e), .sel(sel), .out_data(od[4]), .out_sel(osel[4]), .out_valid(ov[4]), .out_ready(ordy));

  always_comb begin
    rdy[0] = rdy_a;
    rdy[1] = rdy_b;
    rdy[2] = {1'b0, rdy_c};
    rdy[3] = {1'b0, rdy_d};
    rdy[4] = {1'b0, rdy_e};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  // Arbitration rules: lowest valid; first valid at/after ptr with wrap; or sel only.
  function automatic void pick(input int k, input logic [3:0] v, input int s, output bit any, output int g);
    any = 0;
    g   = 0;
    case (pm[k])
      0: for (int i = pn[k] - 1; i >= 0; i--) if (v[i]) begin any = 1; g = i; end
      1: for (int j = pn[k] - 1; j >= 0; j--) begin
           int c;
           c = (mp[k] + j) % pn[k];
           if (v[c]) begin any = 1; g = c; end
         end
      default: if (s < pn[k] && v[s]) begin any = 1; g = s; end
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mv[k] = 0; md[k] = 0; ms[k] = 0; mp[k] = 0;
    end
  endtask

  // Entered just after a rising edge: apply inputs, check, then advance one clock.
  task automatic step(input logic [3:0] v, input logic [1:0] s, input logic r, input logic [31:0] d);
    int nv [NI], nd [NI], ns [NI], np [NI];
    bit any, load;
    int g, er;
    vin = v; sel = s; ordy = r; din = d;
    #1;
    for (int k = 0; k < NI; k++) begin
      pick(k, v, int'(s), any, g);
      load = (mv[k] == 0) || r;
      er   = (load && any) ? (1 << g) : 0;
      chk("in_ready", k, int'(rdy[k]), er);
      chk("out_valid", k, int'(ov[k]), mv[k]);
      chk("out_data", k, int'(od[k]), md[k]);
      chk("out_sel", k, int'(osel[k]), ms[k]);
      nv[k] = mv[k]; nd[k] = md[k]; ns[k] = ms[k]; np[k] = mp[k];
      if (load) begin
        nv[k] = int'(any);
        if (any) begin
          nd[k] = int'((d >> (8 * g)) & 32'hFF);
          ns[k] = g;
          if (pm[k] == 1) np[k] = (g + 1) % pn[k];
        end
      end
    end
    @(posedge clk);
    #1;
    mv = nv; md = nd; ms = ns; mp = np;
  endtask

  initial begin
    logic [31:0] dd;
    dd = 32'hA3A2A1A0;
    model_reset();
    #1 rst_n = 1'b0;
    vin = 4'hF;
    #3;
    for (int k = 0; k < NI; k++) begin
      chk("rst_out_valid", k, int'(ov[k]), 0);
      chk("rst_out_data", k, int'(od[k]), 0);
      chk("rst_in_ready", k, int'(rdy[k]), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin fairness, one beat per cycle
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 2'd2, 1'b1, dd);
      chk("rr4_sel", 0, int'(osel[0]), i % 4);
      chk("rr4_data", 0, int'(od[0]), 'hA0 + i % 4);
      chk("rr3_sel", 3, int'(osel[3]), i % 3);
      chk("rr3_data", 3, int'(od[3]), 'hA0 + i % 3);
      chk("fixed_all", 2, int'(osel[2]), 0);
    end

    // Sparse requests: ptr 1 -> grant 1 (ptr 2) -> 0011 grants 0 then 1
    step(4'b0010, 2'd2, 1'b1, dd);
    chk("sparse_a", 0, int'(osel[0]), 1);
    step(4'b0011, 2'd2, 1'b1, dd);
    chk("sparse_wrap", 0, int'(osel[0]), 0);
    step(4'b0011, 2'd2, 1'b1, dd);
    chk("sparse_next", 0, int'(osel[0]), 1);

    // Backpressure for three cycles, then drain and fill at one edge
    for (int i = 0; i < 3; i++) step(4'hF, 2'd2, 1'b0, dd);
    chk("bp_sel", 0, int'(osel[0]), 1);
    chk("bp_data", 0, int'(od[0]), 'hA1);
    chk("bp_ready", 0, int'(rdy[0]), 0);
    step(4'hF, 2'd2, 1'b1, dd);
    chk("bp_release", 0, int'(osel[0]), 2);

    // Steered mode
    step(4'b1011, 2'd2, 1'b1, dd);
    chk("steer_none", 1, int'(ov[1]), 0);
    step(4'b1011, 2'd3, 1'b1, dd);
    chk("steer_valid", 1, int'(ov[1]), 1);
    chk("steer_sel", 1, int'(osel[1]), 3);
    chk("steer_oor", 4, int'(ov[4]), 0);

    // Fixed priority N=3
    step(4'b0110, 2'd0, 1'b1, dd);
    chk("fixed_110", 2, int'(osel[2]), 1);

    for (int i = 0; i < 1500; i++)
      step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), $urandom);

    // Reset in the middle of a stall
    step(4'hF, 2'd0, 1'b1, dd);
    step(4'hF, 2'd0, 1'b0, dd);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("midrst_out_valid", k, int'(ov[k]), 0);
      chk("midrst_in_ready", k, int'(rdy[k]), 0);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'hF, 2'd0, 1'b1, dd);
    chk("post_rst_sel", 0, int'(osel[0]), 0);
    chk("post_rst_valid", 0, int'(ov[0]), 1);

    for (int i = 0; i < 500; i++)
      step(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
